// File: rtl/vector_cpu_top_pkg.sv
// Shared types and constants for the vector image engine and its VGA scan-out.
package vector_cpu_top_pkg;

    typedef enum logic [1:0] {
        OP_COPY     = 2'd0,
        OP_INVERT   = 2'd1,
        OP_BRIGHTEN = 2'd2,
        OP_THRESH   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned LANES    = 4;
    localparam int unsigned IMG_DIM  = 16;
    localparam int unsigned IMG_SIZE = IMG_DIM * IMG_DIM;

    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned V_VISIBLE    = 480;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;

    function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] x);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, x} + 9'd64;
        unique case (op)
            OP_COPY:     res = x;
            OP_INVERT:   res = ~x;
            OP_BRIGHTEN: res = sum[8] ? 8'hFF : sum[7:0];
            OP_THRESH:   res = x[7] ? 8'hFF : 8'h00;
            default:     res = x;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vector_cpu_top_vga_timing.sv
// 640x480 VGA timing: divide-by-two pixel clock, h/v counters and registered active-low syncs.
module vga_timing
    import vector_cpu_top_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       clk_vga,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync
);

    logic       clk_vga_q, clk_vga_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    always_comb begin
        clk_vga_d = ~clk_vga_q;
        h_d       = h_q;
        v_d       = v_q;
        // pixel tick is the edge on which clk_vga falls
        if (clk_vga_q) begin
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        hsync_d = !((h_d >= 10'(H_SYNC_START)) && (h_d < 10'(H_SYNC_END)));
        vsync_d = !((v_d >= 10'(V_SYNC_START)) && (v_d < 10'(V_SYNC_END)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_vga_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            clk_vga_q <= clk_vga_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign clk_vga = clk_vga_q;
    assign h_cnt   = h_q;
    assign v_cnt   = v_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule

// File: rtl/vector_cpu_top.sv
// Four-lane vector engine transforming a 16x16 grey ROM image into a frame buffer,
// displayed 16x-scaled in the top-left corner of a VGA frame.
module vector_cpu_top
    import vector_cpu_top_pkg::*;
(
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] select,
    output logic       EndFlag,
    output logic       clk_vga,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue
);

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    op_e        sel_q, sel_d;
    logic [7:0] fb_q [IMG_SIZE];
    logic [7:0] fb_d [IMG_SIZE];
    logic [7:0] src_rom [IMG_SIZE];

    logic [9:0] h_cnt, v_cnt;
    logic       in_image;
    logic [7:0] pix_addr;
    logic [7:0] pix;

    always_comb begin
        for (int unsigned i = 0; i < IMG_SIZE; i++) begin
            src_rom[i] = 8'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        fb_d    = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sel_d   = op_e'(select);
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (!pause) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        fb_d[idx_q + 8'(l)] = apply_op(sel_q, src_rom[idx_q + 8'(l)]);
                    end
                    // idx wraps to 0 after the last group, ready for the next run
                    idx_d = idx_q + 8'(LANES);
                    if (idx_q == 8'(IMG_SIZE - LANES)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sel_q   <= OP_COPY;
            fb_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            fb_q    <= fb_d;
        end
    end

    assign EndFlag = (state_q == ST_DONE);

    vga_timing u_vga (
        .clk     (clk_50),
        .rst_n   (reset),
        .clk_vga (clk_vga),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .hsync   (hsync_out),
        .vsync   (vsync_out)
    );

    assign in_image = (h_cnt < 10'(IMG_SIZE)) && (v_cnt < 10'(IMG_SIZE))
                   && (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    assign pix_addr = 8'((v_cnt / 10'(IMG_DIM)) * 10'(IMG_DIM) + h_cnt / 10'(IMG_DIM));

    // display reads the registered buffer, so a same-cycle write shows after its edge
    always_comb begin
        pix = '0;
        if (in_image) begin
            pix = fb_q[pix_addr];
        end
    end

    assign o_red   = pix;
    assign o_green = pix;
    assign o_blue  = pix;

endmodule

// File: tb/tb_vector_cpu_top.sv
// Scoreboard bench: stimulus queues expected run completions; monitors check the
// engine result and every VGA line against a behavioural model.
module tb_vector_cpu_top;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic [1:0] select;
    logic       EndFlag;
    logic       clk_vga;
    logic       hsync_out, vsync_out;
    logic [7:0] o_red, o_green, o_blue;

    vector_cpu_top dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .select    (select),
        .EndFlag   (EndFlag),
        .clk_vga   (clk_vga),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .o_red     (o_red),
        .o_green   (o_green),
        .o_blue    (o_blue)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        int unsigned end_edge;
        logic [1:0]  op;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned k        = 0;
    logic [7:0]  model_fb [256];
    bit          running  = 1'b0;

    // edges since reset release
    always @(posedge clk_50 or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    function automatic int unsigned ref_op(input logic [1:0] op, input int unsigned x);
        case (op)
            2'd0:    return x;
            2'd1:    return 255 - x;
            2'd2:    return (x + 64 > 255) ? 255 : x + 64;
            default: return (x >= 128) ? 255 : 0;
        endcase
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_50);
        #2;
    endtask

    task automatic fb_vs_model(output int unsigned n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.fb_q[i] !== model_fb[i]) n++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model_fb[i] = 8'd0;
    endtask

    // engine monitor: on each EndFlag rise, pop the expected run and check it
    initial begin
        bit end_prev = 1'b0;
        forever begin
            @(negedge clk_50);
            if (!reset) begin
                end_prev = 1'b0;
            end else begin
                if (EndFlag && !end_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_end", 1, 0);
                    end else begin
                        exp_t e;
                        int unsigned bad;
                        e = sb.pop_front();
                        check("end_latency", k, e.end_edge);
                        bad = 0;
                        for (int i = 0; i < 256; i++) begin
                            if (int'(dut.fb_q[i]) != ref_op(e.op, i)) bad++;
                            model_fb[i] = 8'(ref_op(e.op, i));
                        end
                        check("fb_image_mismatches", bad, 0);
                    end
                end
                end_prev = EndFlag;
            end
        end
    end

    // VGA monitor: per full line, sync/clock/pixel errors and hsync-low count
    initial begin
        int unsigned line_err = 0, hs_low = 0, samples = 0;
        forever begin
            @(negedge clk_50);
            if (!reset) begin
                line_err = 0; hs_low = 0; samples = 0;
            end else begin
                int unsigned h, v, exp_pix;
                h = (k / 2) % 800;
                v = (k / 1600) % 525;
                if (k % 1600 == 0) begin
                    line_err = 0; hs_low = 0; samples = 0;
                end
                samples++;
                if (hsync_out !== ((h >= 656 && h < 752) ? 1'b0 : 1'b1)) line_err++;
                if (vsync_out !== ((v >= 490 && v < 492) ? 1'b0 : 1'b1)) line_err++;
                if (clk_vga !== 1'(k % 2)) line_err++;
                if (hsync_out == 1'b0) hs_low++;
                if (!running) begin
                    exp_pix = (h < 256 && v < 256) ? int'(model_fb[(v / 16) * 16 + h / 16]) : 0;
                    if (int'(o_red) != exp_pix || int'(o_green) != exp_pix || int'(o_blue) != exp_pix)
                        line_err++;
                end
                if (k % 1600 == 1599 && samples == 1600) begin
                    check("vga_line_errors", line_err, 0);
                    check("hsync_low_cycles", hs_low, 192);
                end
            end
        end
    end

    task automatic do_run(input logic [1:0] op, input int unsigned lead,
                          input int unsigned pct, input int unsigned abort_at);
        bit          pat[$];
        int unsigned cnt, n, k0, nd;
        bit          got;
        pat.push_back(1'b0);
        cnt = 0;
        while (cnt < 64) begin
            bit p;
            p = (pat.size() <= lead) ? 1'b1 : ($urandom_range(99) < pct);
            pat.push_back(p);
            if (!p) cnt++;
        end
        n  = pat.size() - 1;
        k0 = k;
        running = 1'b1;
        select  = op;
        start   = 1'b1;
        pause   = 1'b1;
        if (abort_at == 0) sb.push_back('{end_edge: k0 + n + 1, op: op});
        for (int unsigned j = 1; j <= n; j++) begin
            step();
            if (abort_at != 0 && j == abort_at + 1) begin
                reset = 1'b0;
                #1;
                fb_vs_model(nd);
                check("abort_fb_nonzero", nd + 0, nd == 0 ? 0 : nd);
                clear_model();
                fb_vs_model(nd);
                check("abort_fb_cleared", nd, 0);
                check("abort_endflag", EndFlag, 0);
                check("abort_syncs", {hsync_out, vsync_out, clk_vga}, 3'b110);
                start = 1'b0;
                repeat (3) step();
                running = 1'b0;
                reset = 1'b1;
                return;
            end
            pause  = pat[j];
            select = 2'($urandom);
            if (lead != 0 && j == lead) begin
                fb_vs_model(nd);
                check("paused_fb_changed", nd, 0);
                check("paused_endflag", EndFlag, 0);
            end
        end
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = EndFlag;
        end
        check("end_seen", got, 1);
        repeat ($urandom_range(3)) begin
            step();
            check("done_hold", EndFlag, 1);
        end
        case (op)
            2'd1: begin check("inv_fb5", dut.fb_q[5], 250); check("inv_fb0", dut.fb_q[0], 255); end
            2'd2: begin check("bri_fb10", dut.fb_q[10], 74); check("bri_fb200", dut.fb_q[200], 255); end
            2'd3: begin check("thr_fb127", dut.fb_q[127], 0); check("thr_fb128", dut.fb_q[128], 255); end
            default: check("copy_fb77", dut.fb_q[77], 77);
        endcase
        start = 1'b0;
        pause = 1'b0;
        step();
        check("end_clear", EndFlag, 0);
        running = 1'b0;
    endtask

    initial begin
        int unsigned nd;
        clear_model();
        reset = 1'b0; start = 1'b0; pause = 1'b0; select = 2'd0;
        repeat (3) step();
        check("rst_endflag", EndFlag, 0);
        check("rst_syncs", {hsync_out, vsync_out}, 2'b11);
        check("rst_clk_vga", clk_vga, 0);
        check("rst_colours", {o_red, o_green, o_blue}, 0);
        fb_vs_model(nd);
        check("rst_fb_zero", nd, 0);
        reset = 1'b1;
        repeat (40) step();

        do_run(2'd0, 50, 0, 0);
        repeat ($urandom_range(20, 80)) step();
        do_run(2'd1, 0, 25, 0);
        repeat ($urandom_range(20, 80)) step();
        do_run(2'd2, 0, 25, 0);
        repeat ($urandom_range(20, 80)) step();
        do_run(2'd3, 0, 25, 0);
        repeat ($urandom_range(20, 80)) step();
        do_run(2'($urandom), 0, 0, 32);
        do_run(2'($urandom), 0, 20, 0);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(10, 200)) step();
            do_run(2'($urandom), 0, $urandom_range(40), 0);
        end
        repeat (3300) step();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "timeout");
    end

endmodule
